// File: rtl/display_capture_if.sv
// Scan-side and result-side signals of the 7-segment display capture monitor.
// The master drives the display scan. The slave is the capture block.
interface display_capture_if;
    logic [3:0]  digit_select;
    logic [6:0]  led_select;
    logic [13:0] number;
    logic        number_valid;
    logic        number_changed;
    logic        digit_err;
    logic        stale;

    modport master (
        output digit_select, led_select,
        input  number, number_valid, number_changed, digit_err, stale
    );

    modport slave (
        input  digit_select, led_select,
        output number, number_valid, number_changed, digit_err, stale
    );
endinterface

// File: rtl/display_capture.sv
// Watches a multiplexed 4-digit 7-segment scan, debounces each digit and
// converts a complete frame into a binary value with change/stale reporting.
module display_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 2**21
) (
    input  logic              clk,
    input  logic              reset,
    display_capture_if.slave  dif
);
    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [CW-1:0] CMAX = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMAX = TW'(FRAME_TIMEOUT);

    typedef enum logic [1:0] {COLLECT, CONVERT, DONE} state_e;

    state_e          state_q, state_d;
    logic [10:0]     prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0][3:0] slot_q, slot_d;
    logic [3:0]      cap_q, cap_d;
    logic [1:0]      idx_q, idx_d;
    logic [13:0]     acc_q, acc_d;
    logic [13:0]     number_q, number_d;
    logic            valid_q, valid_d;
    logic            changed_q, changed_d;
    logic            err_q, err_d;
    logic [TW-1:0]   stale_cnt_q, stale_cnt_d;

    logic            sample_en, conv_step, done_ld;
    logic            onehot, same, hit;
    logic [1:0]      sel;
    logic [4:0]      dec;

    // {ok, bcd}; a blank digit reads as zero.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40, 7'h7F: decode = {1'b1, 4'd0};
            7'h79:        decode = {1'b1, 4'd1};
            7'h24:        decode = {1'b1, 4'd2};
            7'h30:        decode = {1'b1, 4'd3};
            7'h19:        decode = {1'b1, 4'd4};
            7'h12:        decode = {1'b1, 4'd5};
            7'h02:        decode = {1'b1, 4'd6};
            7'h78:        decode = {1'b1, 4'd7};
            7'h00:        decode = {1'b1, 4'd8};
            7'h10:        decode = {1'b1, 4'd9};
            default:      decode = 5'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            prev_q      <= '0;
            cnt_q       <= '0;
            slot_q      <= '0;
            cap_q       <= '0;
            idx_q       <= 2'd3;
            acc_q       <= '0;
            number_q    <= '0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
            err_q       <= 1'b0;
            stale_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= {dif.digit_select, dif.led_select};
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            cap_q       <= cap_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            number_q    <= number_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
            err_q       <= err_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (cap_d == 4'hF) state_d = CONVERT;
            CONVERT: if (idx_q == 2'd0) state_d = DONE;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        sample_en = (state_q == COLLECT);
        conv_step = (state_q == CONVERT);
        done_ld   = (state_q == DONE);
    end

    always_comb begin
        onehot = 1'b1;
        sel    = 2'd0;
        case (dif.digit_select)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: onehot = 1'b0;
        endcase
        same = ({dif.digit_select, dif.led_select} == prev_q);
        dec  = decode(dif.led_select);

        // Saturating at CMAX gives exactly one sample per dwell.
        if (!onehot || !same || conv_step)
            cnt_d = '0;
        else if (cnt_q == CMAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
        hit = sample_en && (cnt_d == CMAX) && (cnt_q != CMAX);

        slot_d      = slot_q;
        cap_d       = cap_q;
        err_d       = 1'b0;
        acc_d       = acc_q;
        idx_d       = idx_q;
        number_d    = number_q;
        valid_d     = 1'b0;
        changed_d   = 1'b0;

        if (hit) begin
            if (dec[4]) begin
                slot_d[sel] = dec[3:0];
                cap_d[sel]  = 1'b1;
            end else begin
                err_d       = 1'b1;
                cap_d[sel]  = 1'b0;
            end
        end

        // idx wraps 0 -> 3, ready for the next frame.
        if (conv_step) begin
            acc_d = (acc_q << 3) + (acc_q << 1) + {10'd0, slot_q[idx_q]};
            idx_d = idx_q - 2'd1;
        end

        if (done_ld) begin
            number_d  = acc_q;
            valid_d   = 1'b1;
            changed_d = (acc_q != number_q);
            cap_d     = '0;
            acc_d     = '0;
        end

        if (done_ld)
            stale_cnt_d = '0;
        else if (stale_cnt_q == TMAX)
            stale_cnt_d = stale_cnt_q;
        else
            stale_cnt_d = stale_cnt_q + 1'b1;
    end

    assign dif.number         = number_q;
    assign dif.number_valid   = valid_q;
    assign dif.number_changed = changed_q;
    assign dif.digit_err      = err_q;
    assign dif.stale          = (stale_cnt_q == TMAX);
endmodule
